// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of the
// two-requester ALU arbiter, with arbiter (slave) and client (master) views.
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3,
   parameter int CNTW  = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp_data;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_s;
   logic [WIDTH-1:0] alu_result;
   logic             busy;
   logic [CNTW-1:0]  op_count;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready, alu_result,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data,
      output alu_a, alu_b, alu_s, busy, op_count
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready, alu_result,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data,
      input  alu_a, alu_b, alu_s, busy, op_count
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer for a shared combinational ALU.
// IDLE accepts one request, EXEC captures the result, RESP returns it.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3,
   parameter int CNTW  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last;
   logic             r_owner;
   logic             r_busy;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic [WIDTH-1:0] r_rsp_data;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [OPW-1:0]   r_alu_s;
   logic [CNTW-1:0]  r_op_count;

   logic w_idle;
   logic w_win1;
   logic w_ready0;
   logic w_ready1;
   logic w_rsp_take;

   // Winner select: a lone requester wins, contention goes to the one not granted last
   always_comb begin
      w_idle     = (r_state == IDLE);
      w_win1     = bus.req1_valid & (~bus.req0_valid | ~r_last);
      w_ready0   = rst_n & w_idle & bus.req0_valid & ~w_win1;
      w_ready1   = rst_n & w_idle & w_win1;
      w_rsp_take = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
   end

   // Sequencer FSM with registered ALU drive, response and counter outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last       <= 1'b1;
         r_owner      <= 1'b0;
         r_busy       <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp_data   <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_s      <= '0;
         r_op_count   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_ready0 | w_ready1) begin
                  r_alu_a <= w_ready1 ? bus.req1_a  : bus.req0_a;
                  r_alu_b <= w_ready1 ? bus.req1_b  : bus.req0_b;
                  r_alu_s <= w_ready1 ? bus.req1_op : bus.req0_op;
                  r_owner <= w_ready1;
                  r_last  <= w_ready1;
                  r_busy  <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_data   <= bus.alu_result;
               r_rsp0_valid <= ~r_owner;
               r_rsp1_valid <= r_owner;
               r_state      <= RESP;
            end
            RESP: begin
               if (w_rsp_take) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_op_count   <= r_op_count + 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;
   assign bus.rsp0_valid = r_rsp0_valid;
   assign bus.rsp1_valid = r_rsp1_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_s      = r_alu_s;
   assign bus.busy       = r_busy;
   assign bus.op_count   = r_op_count;

endmodule
